clk_div_prog: RTL and testbench

//   Runtime-programmable clock divider / tick generator; next generation of the fixed-value divider.

---
 rtl/clk_div_prog.sv | 108 ++++++++++
 tb/tb_clk_div_prog.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider / tick generator with a shadowed divide value.
// New values take effect only on a terminal count, so clk_d never shows a runt phase.
module clk_div_prog #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DEFAULT_DIV  = 1,
   parameter bit          DEFAULT_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_mode,
   input  logic             div_load,
   output logic             clk_d,
   output logic             tick,
   output logic             div_ack,
   output logic             pending
);

   localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_n_q, act_n_d;
   logic [CNT_W-1:0] shd_n_q, shd_n_d;
   logic             act_mode_q, act_mode_d;
   logic             shd_mode_q, shd_mode_d;
   logic             pending_q, pending_d;
   logic             clk_d_q, clk_d_d;
   logic             tick_q, tick_d;
   logic             div_ack_q, div_ack_d;
   logic             term;

   always_comb begin
      term       = en && (cnt_q == act_n_q);
      cnt_d      = cnt_q;
      act_n_d    = act_n_q;
      act_mode_d = act_mode_q;
      shd_n_d    = shd_n_q;
      shd_mode_d = shd_mode_q;
      pending_d  = pending_q;
      div_ack_d  = 1'b0;
      tick_d     = term;

      if (term) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // A load coinciding with the boundary bypasses the shadow entirely.
      if (term && div_load) begin
         act_n_d    = div_val;
         act_mode_d = div_mode;
         pending_d  = 1'b0;
         div_ack_d  = 1'b1;
      end else if (term && pending_q) begin
         act_n_d    = shd_n_q;
         act_mode_d = shd_mode_q;
         pending_d  = 1'b0;
         div_ack_d  = 1'b1;
      end else if (!term && div_load) begin
         shd_n_d    = div_val;
         shd_mode_d = div_mode;
         pending_d  = 1'b1;
      end

      // Output follows the mode in force for the next cycle; pulse->square restarts low.
      if (act_mode_d) begin
         clk_d_d = term;
      end else if (act_mode_q) begin
         clk_d_d = 1'b0;
      end else if (term) begin
         clk_d_d = ~clk_d_q;
      end else begin
         clk_d_d = clk_d_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         act_n_q    <= DEF_N;
         act_mode_q <= DEFAULT_MODE;
         shd_n_q    <= '0;
         shd_mode_q <= 1'b0;
         pending_q  <= 1'b0;
         clk_d_q    <= 1'b0;
         tick_q     <= 1'b0;
         div_ack_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         act_n_q    <= act_n_d;
         act_mode_q <= act_mode_d;
         shd_n_q    <= shd_n_d;
         shd_mode_q <= shd_mode_d;
         pending_q  <= pending_d;
         clk_d_q    <= clk_d_d;
         tick_q     <= tick_d;
         div_ack_q  <= div_ack_d;
      end
   end

   assign clk_d   = clk_d_q;
   assign tick    = tick_q;
   assign div_ack = div_ack_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: hand-derived per-cycle output vectors {clk_d,tick,div_ack,pending}
// are queued as stimulus is driven and compared one cycle later.
module tb_clk_div_prog;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] div_val;
   logic        div_mode;
   logic        div_load;
   logic        clk_d;
   logic        tick;
   logic        div_ack;
   logic        pending;

   int n_total;
   int n_bad;
   logic [3:0] exp_q[$];

   clk_div_prog #(
      .CNT_W       (16),
      .DEFAULT_DIV (1),
      .DEFAULT_MODE(1'b0)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .div_val (div_val),
      .div_mode(div_mode),
      .div_load(div_load),
      .clk_d   (clk_d),
      .tick    (tick),
      .div_ack (div_ack),
      .pending (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out(input string tag, input logic [3:0] got, input logic [3:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got {clk_d,tick,ack,pend}=%b want %b at %0t", tag, got, want, $time);
      end
   endtask

   // Drive one cycle of inputs, queue the expected outputs after the next edge, then compare.
   task automatic step(input string tag, input logic e, input logic ld, input logic [15:0] v,
                       input logic m, input logic [3:0] want);
      logic [3:0] w;
      en       = e;
      div_load = ld;
      div_val  = v;
      div_mode = m;
      exp_q.push_back(want);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_total++;
         n_bad++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         w = exp_q.pop_front();
         check_out(tag, {clk_d, tick, div_ack, pending}, w);
      end
   endtask

   task automatic run_n1_square(input string tag);
      for (int k = 1; k <= 8; k++)
         step(tag, 1'b1, 1'b0, 16'd0, 1'b0, {((k / 2) % 2) == 1, (k % 2) == 0, 2'b00});
   endtask

   initial begin
      n_total  = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      div_val  = '0;
      div_mode = 1'b0;
      div_load = 1'b0;
      #12;
      check_out("reset", {clk_d, tick, div_ack, pending}, 4'b0000);
      rst_n = 1'b1;

      // Default N=1 square: period 4, tick every 2.
      run_n1_square("t1_default");

      // Load N=3 square at cnt=0: pending one cycle, applied at next term.
      step("t2_load", 1'b1, 1'b1, 16'd3, 1'b0, 4'b0001);
      step("t2_apply", 1'b1, 1'b0, 16'd0, 1'b0, 4'b1110);
      for (int j = 1; j <= 16; j++)
         step("t2_n3", 1'b1, 1'b0, 16'd0, 1'b0, {((j / 4) % 2) == 0, (j % 4) == 0, 2'b00});

      // Load N=4 pulse at cnt=0 (clk_d high); applied after the remaining half-period.
      step("t3_load", 1'b1, 1'b1, 16'd4, 1'b1, 4'b1001);
      step("t3_wait", 1'b1, 1'b0, 16'd0, 1'b0, 4'b1001);
      step("t3_wait", 1'b1, 1'b0, 16'd0, 1'b0, 4'b1001);
      step("t3_apply", 1'b1, 1'b0, 16'd0, 1'b0, 4'b1110);
      for (int m = 1; m <= 19; m++) begin
         logic hit;
         hit = (m % 5) == 0;
         step("t3_pulse", 1'b1, 1'b0, 16'd0, 1'b0, {hit, hit, 2'b00});
      end

      // Load on the terminal-count cycle: bypass to N=2 square, clk_d restarts low.
      step("t4_bypass", 1'b1, 1'b1, 16'd2, 1'b0, 4'b0110);
      for (int p = 1; p <= 6; p++)
         step("t4_n2", 1'b1, 1'b0, 16'd0, 1'b0, {((p / 3) % 2) == 1, (p % 3) == 0, 2'b00});

      // Two loads before the boundary: last (7) wins, single ack.
      step("t4_ld5", 1'b1, 1'b1, 16'd5, 1'b0, 4'b0001);
      step("t4_ld7", 1'b1, 1'b1, 16'd7, 1'b0, 4'b0001);
      step("t4_apply7", 1'b1, 1'b0, 16'd0, 1'b0, 4'b1110);
      for (int r = 1; r <= 16; r++)
         step("t4_n7", 1'b1, 1'b0, 16'd0, 1'b0, {((r / 8) % 2) == 0, (r % 8) == 0, 2'b00});

      // Freeze mid-period at cnt=3 for 10 cycles, with a load captured while frozen.
      for (int s = 1; s <= 3; s++)
         step("t5_run", 1'b1, 1'b0, 16'd0, 1'b0, 4'b1000);
      for (int s = 1; s <= 10; s++) begin
         if (s == 5) step("t5_ld_frozen", 1'b0, 1'b1, 16'd1, 1'b0, 4'b1001);
         else if (s > 5) step("t5_frozen_p", 1'b0, 1'b0, 16'd0, 1'b0, 4'b1001);
         else step("t5_frozen", 1'b0, 1'b0, 16'd0, 1'b0, 4'b1000);
      end
      for (int t = 1; t <= 4; t++)
         step("t5_resume", 1'b1, 1'b0, 16'd0, 1'b0, 4'b1001);
      step("t5_apply", 1'b1, 1'b0, 16'd0, 1'b0, 4'b0110);
      for (int u = 1; u <= 4; u++)
         step("t5_n1", 1'b1, 1'b0, 16'd0, 1'b0, {((u / 2) % 2) == 1, (u % 2) == 0, 2'b00});

      // Async reset with a pending shadow: everything clears, shadow lost.
      step("t6_load", 1'b1, 1'b1, 16'd6, 1'b0, 4'b0001);
      #2 rst_n = 1'b0;
      #1 check_out("t6_async_rst", {clk_d, tick, div_ack, pending}, 4'b0000);
      @(posedge clk);
      #1 check_out("t6_rst_held", {clk_d, tick, div_ack, pending}, 4'b0000);
      #3 rst_n = 1'b1;
      run_n1_square("t6_after_rst");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
